// File: rtl/fq_ingress.sv
// fq_ingress: packet-framing writer for the fair-queue scheduler's per-flow
// input FIFOs. Each packet is buffered whole so that its word count can be
// stamped into bits [7:0] of every record written out. Packets longer than
// MAX_PKT words are discarded in full.
//
// Compile-time option:
//   FQ_INGRESS_STATS_EN - when defined, drop_count counts dropped packets
//                         (saturating). When undefined, drop_count is 0 and
//                         no counter is built.
//
// Handshake: a word moves when in_valid && in_ready in the same cycle.
// in_valid must not depend on in_ready. fifo_wrreq is a single-cycle
// write strobe and is only raised when the matching fifo_full is low.
// The FSM state is the internal signal 'state' (type state_t).
module fq_ingress #(
    parameter int NUM_IN_LOG2 = 3,
    parameter int MAX_PKT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [55:0]            in_data,
    input  logic [NUM_IN_LOG2-1:0] in_flow,
    input  logic                   in_last,
    output logic                   fifo_wrreq [1 << NUM_IN_LOG2],
    input  logic                   fifo_full  [1 << NUM_IN_LOG2],
    output logic [63:0]            fifo_wdata,
    output logic [15:0]            drop_count
);

    localparam int         N     = 1 << NUM_IN_LOG2;
    // Buffer index width; one bit minimum so MAX_PKT == 1 still works.
    localparam int         AW    = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam logic [7:0] MAX_W = 8'(MAX_PKT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DROP    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t                 state;
    logic [7:0]             wr_ptr;   // words held; doubles as the stamped count
    logic [7:0]             rd_ptr;
    logic [NUM_IN_LOG2-1:0] flow_q;
    logic [55:0]            pkt_buf [1 << AW];

    logic xfer;
    logic wr_fire;

    assign in_ready = !rst && (state != S_DRAIN);
    assign xfer     = in_valid && in_ready;
    assign wr_fire  = !rst && (state == S_DRAIN) && !fifo_full[flow_q];

    // Packet buffer storage; overflow words are simply not stored.
    always_ff @(posedge clk) begin
        if (xfer && state == S_IDLE) begin
            pkt_buf[0] <= in_data;
        end else if (xfer && state == S_COLLECT && wr_ptr < MAX_W) begin
            pkt_buf[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Framing FSM: collect a packet, then drain it into the selected FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_ptr <= 8'd0;
            rd_ptr <= 8'd0;
            flow_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        flow_q <= in_flow;
                        wr_ptr <= 8'd1;
                        state  <= in_last ? S_DRAIN : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (xfer) begin
                        if (wr_ptr < MAX_W) begin
                            wr_ptr <= wr_ptr + 8'd1;
                            if (in_last) state <= S_DRAIN;
                        end else begin
                            // Overflow: this word and the rest are thrown away.
                            wr_ptr <= 8'd0;
                            state  <= in_last ? S_IDLE : S_DROP;
                        end
                    end
                end
                S_DROP: begin
                    if (xfer && in_last) state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (wr_fire) begin
                        if (rd_ptr == wr_ptr - 8'd1) begin
                            rd_ptr <= 8'd0;
                            wr_ptr <= 8'd0;
                            state  <= S_IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + 8'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write strobe to the latched flow only, data shared by all FIFOs.
    always_comb begin
        for (int i = 0; i < N; i++) fifo_wrreq[i] = 1'b0;
        fifo_wrreq[flow_q] = wr_fire;
        fifo_wdata         = {pkt_buf[rd_ptr[AW-1:0]], wr_ptr};
    end

`ifdef FQ_INGRESS_STATS_EN
    logic        drop_evt;
    logic [15:0] drop_q;

    // One event per dropped packet: either the overflowing word was last,
    // or the packet ends while discarding.
    assign drop_evt = xfer && in_last &&
                      ((state == S_COLLECT && wr_ptr == MAX_W) || state == S_DROP);

    // Saturating dropped-packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 16'd0;
        end else if (drop_evt && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_fq_ingress.sv
// tb_fq_ingress: randomized and directed bench for fq_ingress. The reference
// model turns each sent packet into its expected FIFO records (flow, payload,
// word count) or a drop, and a scoreboard matches every observed write.
module tb_fq_ingress;

  localparam int NL = 3;
  localparam int N  = 1 << NL;
  localparam int MP = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [55:0]   in_data  = '0;
  logic [NL-1:0] in_flow  = '0;
  logic          in_last  = 1'b0;
  logic          fifo_wrreq [N];
  logic          fifo_full  [N];
  logic [63:0]   fifo_wdata;
  logic [15:0]   drop_count;

  fq_ingress #(.NUM_IN_LOG2(NL), .MAX_PKT(MP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_flow    (in_flow),
    .in_last    (in_last),
    .fifo_wrreq (fifo_wrreq),
    .fifo_full  (fifo_full),
    .fifo_wdata (fifo_wdata),
    .drop_count (drop_count)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int wr_total = 0;
  int exp_drops = 0;
  bit rand_full = 1'b0;
  logic [66:0] exp_q[$];   // {flow, payload, count}

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_drop_count();
`ifdef FQ_INGRESS_STATS_EN
    return (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
`else
    return 16'd0;
`endif
  endfunction

  // ---------------- monitor ----------------
  int          mon_n;
  logic [NL-1:0] mon_idx;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", {66'd0, in_ready}, 67'd0);
      for (int i = 0; i < N; i++) check("rst_strobe", {66'd0, fifo_wrreq[i]}, 67'd0);
    end else begin
      mon_n = 0;
      mon_idx = '0;
      for (int i = 0; i < N; i++) begin
        if (fifo_wrreq[i]) begin
          mon_n++;
          mon_idx = NL'(i);
          check("wr_while_full", {66'd0, fifo_full[i]}, 67'd0);
        end
      end
      if (mon_n > 1) check("strobe_onehot", 67'(mon_n), 67'd1);
      if (mon_n == 1) begin
        wr_total++;
        if (exp_q.size() == 0) check("spurious_write", 67'(mon_n), 67'd0);
        else check("wr_record", {mon_idx, fifo_wdata}, exp_q.pop_front());
      end
    end
  end

  // Random backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rand_full) for (int i = 0; i < N; i++) fifo_full[i] = ($urandom_range(0, 3) == 0);
  end

  // ---------------- driver tasks ----------------
  // Sends one packet; returns just after the edge of the last transfer.
  task automatic send_pkt(input int flow, input int len, input bit chg, output int stalls);
    logic [55:0] words[$];
    int guard;
    stalls = 0;
    for (int i = 0; i < len; i++) words.push_back({$urandom, $urandom} & 64'h00FF_FFFF_FFFF_FFFF);
    if (len <= MP) begin
      for (int i = 0; i < len; i++) exp_q.push_back({NL'(flow), words[i], 8'(len)});
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = words[i];
      in_flow  = (i == 0) ? NL'(flow) : (chg ? NL'(1) : NL'($urandom_range(0, N-1)));
      in_last  = (i == len - 1);
      guard = 0;
      while (!in_ready && guard < 200) begin
        stalls++;
        guard++;
        @(negedge clk);
      end
      if (guard >= 200) check("ready_timeout", {66'd0, in_ready}, 67'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Follows a drain cycle by cycle, optionally holding full for a window.
  task automatic drain_check(input int flow, input int k, input int stall_at, input int stall_len);
    int writes = 0;
    int cycles = 0;
    while (writes < k && cycles < k + stall_len + 20) begin
      fifo_full[flow] = (cycles >= stall_at && cycles < stall_at + stall_len);
      @(negedge clk);
      check("drain_ready", {66'd0, in_ready}, 67'd0);
      check("drain_strobe", {66'd0, fifo_wrreq[flow]}, {66'd0, !fifo_full[flow]});
      if (fifo_wrreq[flow]) writes++;
      cycles++;
      @(posedge clk);
      #1;
    end
    fifo_full[flow] = 1'b0;
    @(negedge clk);
    check("drain_cycles", 67'(cycles), 67'(k + stall_len));
    check("ready_after_drain", {66'd0, in_ready}, 67'd1);
  endtask

  task automatic wait_empty(input int budget);
    int g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      g++;
      @(negedge clk);
    end
    check("queue_drained", 67'(exp_q.size()), 67'd0);
  endtask

  // ---------------- stimulus ----------------
  int st;
  int wr_before;
  initial begin
    for (int i = 0; i < N; i++) fifo_full[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {66'd0, in_ready}, 67'd1);
    check("drop_after_rst", {51'd0, drop_count}, {51'd0, exp_drop_count()});

    // 3-word packet to flow 5.
    send_pkt(5, 3, 0, st);
    drain_check(5, 3, 0, 0);
    // Single-word packet to flow 0.
    send_pkt(0, 1, 0, st);
    drain_check(0, 1, 0, 0);
    // Full-size packet with a 5-cycle stall mid-drain.
    send_pkt(2, MP, 0, st);
    drain_check(2, MP, 6, 5);
    // Oversized packet: accepted without stalls, nothing written.
    wr_before = wr_total;
    send_pkt(4, MP + 4, 0, st);
    check("drop_no_stall", 67'(st), 67'd0);
    repeat (3) @(negedge clk);
    check("drop_no_write", 67'(wr_total), 67'(wr_before));
    check("drop_count_1", {51'd0, drop_count}, {51'd0, exp_drop_count()});
    send_pkt(6, 2, 0, st);
    drain_check(6, 2, 0, 0);
    // One word past the limit, ending on the overflow word.
    send_pkt(3, MP + 1, 0, st);
    repeat (2) @(negedge clk);
    check("drop_count_2", {51'd0, drop_count}, {51'd0, exp_drop_count()});
    // Flow change mid-packet is ignored.
    send_pkt(7, 4, 1, st);
    drain_check(7, 4, 0, 0);

    // Reset on the 2nd drain cycle of a 4-word packet.
    send_pkt(3, 4, 0, st);
    @(negedge clk);
    check("rst_pre_write", {66'd0, fifo_wrreq[3]}, 67'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_strobe", {66'd0, fifo_wrreq[3]}, 67'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    @(negedge clk);
    check("rst_mid_ready", {66'd0, in_ready}, 67'd1);
    check("rst_mid_drop", {51'd0, drop_count}, 67'd0);
    send_pkt(1, 3, 0, st);
    drain_check(1, 3, 0, 0);

    // Randomized traffic with random backpressure.
    rand_full = 1'b1;
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom_range(0, N-1), $urandom_range(1, MP + 4), 1'b0, st);
    end
    wait_empty(2000);
    rand_full = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) fifo_full[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("rand_drop_count", {51'd0, drop_count}, {51'd0, exp_drop_count()});
    check("rand_ready_idle", {66'd0, in_ready}, 67'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
